uart_rx_ctrl: RTL and testbench
===============================

Name: uart_rx_ctrl

Overview:
Controller for the UART receive datapath. It generates the 16x oversampling tick (s_tick) that drives the receiver from a programmable divisor. It detects each completed-frame indication from the receiver and buffers received bytes in a small FIFO for the bus side. It also reports status (empty/full/count/overrun) and raises a level interrupt for the APB register block.

Parameters:
DIV_W, 16, width of baud divisor register
DEFAULT_DIV, 326, divisor after reset (50 MHz clk, 9600 baud x16)
DEPTH, 8, FIFO depth in bytes; must be a power of 2, >=2
AW, 3, log2(DEPTH)

Ports:
clk  in  1  system clock, all logic on posedge
rst  in  1  synchronous, active-high reset
en  in  1  receive enable
cfg_div_we  in  1  load cfg_div into divisor register
cfg_div  in  DIV_W  new divisor value
s_tick  out  1  oversampling tick to receiver, one clk wide
rx_data  in  8  received byte from receiver
rx_done  in  1  receiver frame-complete flag (level; may stay high)
rd_en  in  1  pop request from bus side
rd_data  out  8  popped byte
rd_valid  out  1  rd_data valid, one-cycle pulse
flush  in  1  empty the FIFO
ovr_clr  in  1  clear sticky overrun
thresh  in  AW+1  interrupt fill threshold; 0 disables the level term
count  out  AW+1  bytes held
empty  out  1  count==0
full  out  1  count==DEPTH
overrun  out  1  sticky: byte dropped while full
irq  out  1  interrupt

Behaviour:
- Reset: divisor=DEFAULT_DIV, baud counter=0, s_tick=0, FIFO pointers/count=0, rd_data=0, rd_valid=0, overrun=0, irq=0, rx_done history=0.
- Baud gen: counter counts 0..div-1 while en=1. s_tick=1 (registered) on the clk after counter==div-1, then counter wraps to 0. Period is exactly div clks.
- Divisor 0 or 1 yields s_tick every clk.
- cfg_div_we: divisor loads next clk, counter forced to 0. Allowed at any time; an in-progress period is abandoned.
- en=0: counter held 0, s_tick=0, pushes ignored. FIFO contents and reads remain functional.
- Frame capture: rx_done registered each clk. push = rx_done & ~rx_done_q & en. A level held high produces exactly one push; the next push needs a low->high transition.
- push, not full: rx_data written at wr_ptr, wr_ptr+1 (wraps mod DEPTH), count+1.
- push when full: byte dropped, overrun<=1. Exception: simultaneous pop frees a slot, so push accepted, no overrun.
- pop = rd_en & ~empty. rd_data<=mem[rd_ptr], rd_valid<=1 the next clk, rd_ptr+1 (wraps), count-1. Read latency is 1 clk.
- rd_en on empty: ignored, rd_valid=0, no error flag. Simultaneous push+pop on empty: push only; the pop is ignored, not forwarded.
- Simultaneous push+pop, neither boundary: count unchanged, both pointers advance.
- flush: pointers and count to 0 next clk. Overrides push and pop in the same cycle; rd_valid=0 that cycle; overrun unaffected.
- ovr_clr: overrun<=0. If an overflow push occurs in the same cycle, set wins (overrun stays 1).
- irq (registered) = overrun | (thresh!=0 & count>=thresh), evaluated on next-state values.
- Reset mid-frame: all state restarts; the receiver sees s_tick stop and must be reset externally.
- count width AW+1; full when count==DEPTH. Pointers AW bits, natural wrap.

Decomposition:
- Shared package uart_pkg: DEFAULT_DIV, baud oversample constant (16), DATA_W=8.
- One natural sub-module: sync_fifo (parameterised DEPTH/width; push, pop, flush, count, full, empty, registered rd_data).
- Baud generator, edge detect, overrun and irq logic stay in uart_rx_ctrl.

Test Plan:
- Baud: rst, en=1, div=4 -> s_tick pulses every 4 clks. Write cfg_div=10 mid-period -> counter restarts, next pulse 10 clks after load. div=0 -> s_tick every clk.
- Edge capture: rx_data=0xA5, rx_done held high 50 clks -> exactly one push, count=1. rd_en -> rd_data=0xA5, rd_valid=1 one clk later, empty=1.
- Fill/overflow: push 0x01..0x08 -> full=1, count=8. Push 0x09 -> dropped, overrun=1, irq=1. Pop all 8 -> 0x01..0x08 in order. ovr_clr -> overrun=0.
- Full + simultaneous push/pop: full FIFO, push 0x55 with rd_en -> overrun=0, count stays 8, 0x55 read last.
- Threshold/flush: thresh=3, push 3 bytes -> irq=1 on the 3rd. flush with concurrent push -> count=0, irq=0, empty=1.
- Reset/enable: en=0, toggle rx_done -> no push, s_tick=0. Assert rst mid-stream -> all outputs at reset values next clk, divisor=326.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared constants for the UART receive path.
package uart_pkg;

  localparam int unsigned DATA_W     = 8;
  localparam int unsigned OVERSAMPLE = 16;

  // Rounded divisor giving OVERSAMPLE ticks per bit at the requested baud rate.
  function automatic int unsigned calcDiv(input int unsigned clkHz, input int unsigned baud);
    return (clkHz + (baud * OVERSAMPLE) / 2) / (baud * OVERSAMPLE);
  endfunction

  localparam int unsigned DEFAULT_DIV = calcDiv(50_000_000, 9600);

endpackage

// File: rtl/sync_fifo.sv
// Synchronous FIFO with registered read data, flush, and next-state fill count.
module sync_fifo #(
  parameter int unsigned Width = 8,
  parameter int unsigned Depth = 8,
  parameter int unsigned Aw    = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic             flush,
  input  logic [Width-1:0] wrData,
  output logic [Width-1:0] rdData,
  output logic             rdValid,
  output logic [Aw:0]      count,
  output logic [Aw:0]      countNext,
  output logic             full,
  output logic             empty
);

  localparam logic [Aw:0]   CntOne = (Aw+1)'(1);
  localparam logic [Aw-1:0] PtrOne = Aw'(1);

  logic [Width-1:0] mem [Depth];
  logic [Aw-1:0]    wrPtrQ, rdPtrQ;
  logic [Aw:0]      countQ;
  logic             doPush, doPop;

  assign count = countQ;
  assign full  = (countQ == (Aw+1)'(Depth));
  assign empty = (countQ == '0);

  // A pop in the same cycle frees the slot a full-FIFO push needs.
  always_comb begin
    doPop  = pop & ~empty & ~flush;
    doPush = push & (~full | doPop) & ~flush;
    countNext = countQ;
    if (flush) begin
      countNext = '0;
    end else if (doPush && !doPop) begin
      countNext = countQ + CntOne;
    end else if (!doPush && doPop) begin
      countNext = countQ - CntOne;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wrPtrQ  <= '0;
      rdPtrQ  <= '0;
      countQ  <= '0;
      rdData  <= '0;
      rdValid <= 1'b0;
    end else begin
      countQ  <= countNext;
      rdValid <= doPop;
      if (flush) begin
        wrPtrQ <= '0;
        rdPtrQ <= '0;
      end else begin
        if (doPush) wrPtrQ <= wrPtrQ + PtrOne;
        if (doPop) begin
          rdPtrQ <= rdPtrQ + PtrOne;
          rdData <= mem[rdPtrQ];
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (doPush) mem[wrPtrQ] <= wrData;
  end

endmodule

// File: rtl/uart_rx_ctrl.sv
// UART receive controller: oversampling baud tick, frame-complete capture into a FIFO,
// status flags and a level interrupt.
module uart_rx_ctrl #(
  parameter int unsigned DIV_W       = 16,
  parameter int unsigned DEFAULT_DIV = uart_pkg::DEFAULT_DIV,
  parameter int unsigned DEPTH       = 8,
  parameter int unsigned AW          = 3
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        en,
  input  logic                        cfg_div_we,
  input  logic [DIV_W-1:0]            cfg_div,
  output logic                        s_tick,
  input  logic [uart_pkg::DATA_W-1:0] rx_data,
  input  logic                        rx_done,
  input  logic                        rd_en,
  output logic [uart_pkg::DATA_W-1:0] rd_data,
  output logic                        rd_valid,
  input  logic                        flush,
  input  logic                        ovr_clr,
  input  logic [AW:0]                 thresh,
  output logic [AW:0]                 count,
  output logic                        empty,
  output logic                        full,
  output logic                        overrun,
  output logic                        irq
);
  import uart_pkg::*;

  localparam logic [DIV_W-1:0] DivOne = DIV_W'(1);

  logic [DIV_W-1:0] divQ, baudCntQ;
  logic             tickQ, rxDoneQ, overrunQ, overrunD, irqQ;
  logic             push, pop, overflow;
  logic [AW:0]      countNext;

  assign s_tick  = tickQ;
  assign overrun = overrunQ;
  assign irq     = irqQ;

  // Set wins over clear; a flush swallows the push so it cannot overflow.
  always_comb begin
    push     = rx_done & ~rxDoneQ & en;
    pop      = rd_en & ~empty;
    overflow = push & full & ~pop & ~flush;
    overrunD = overrunQ;
    if (ovr_clr) overrunD = 1'b0;
    if (overflow) overrunD = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      divQ     <= DIV_W'(DEFAULT_DIV);
      baudCntQ <= '0;
      tickQ    <= 1'b0;
    end else if (cfg_div_we) begin
      divQ     <= cfg_div;
      baudCntQ <= '0;
      tickQ    <= 1'b0;
    end else if (!en) begin
      baudCntQ <= '0;
      tickQ    <= 1'b0;
    end else if (divQ <= DivOne || baudCntQ == divQ - DivOne) begin
      baudCntQ <= '0;
      tickQ    <= 1'b1;
    end else begin
      baudCntQ <= baudCntQ + DivOne;
      tickQ    <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rxDoneQ  <= 1'b0;
      overrunQ <= 1'b0;
      irqQ     <= 1'b0;
    end else begin
      rxDoneQ  <= rx_done;
      overrunQ <= overrunD;
      irqQ     <= overrunD | ((thresh != '0) && (countNext >= thresh));
    end
  end

  sync_fifo #(
    .Width(DATA_W),
    .Depth(DEPTH),
    .Aw   (AW)
  ) u_fifo (
    .clk      (clk),
    .rst      (rst),
    .push     (push),
    .pop      (pop),
    .flush    (flush),
    .wrData   (rx_data),
    .rdData   (rd_data),
    .rdValid  (rd_valid),
    .count    (count),
    .countNext(countNext),
    .full     (full),
    .empty    (empty)
  );

endmodule

// File: tb/tb_uart_rx_ctrl.sv
// Self-checking bench for uart_rx_ctrl: directed scenarios plus randomized traffic
// checked against a queue-based reference model.
module tb_uart_rx_ctrl;

  localparam int DEPTH = 8;

  logic        clk = 1'b0;
  logic        rst, en, cfg_div_we, rx_done, rd_en, flush, ovr_clr;
  logic [15:0] cfg_div;
  logic [7:0]  rx_data, rd_data;
  logic [3:0]  thresh, count;
  logic        s_tick, rd_valid, empty, full, overrun, irq;

  int nChecks = 0;
  int nFails  = 0;

  // Reference model state.
  int          mDiv, mElapsed;
  bit          mTick, mPrevDone, mRdValid, mOverrun, mIrq;
  logic [7:0]  mRdData;
  logic [7:0]  mQ[$];

  uart_rx_ctrl dut (
    .clk       (clk),
    .rst       (rst),
    .en        (en),
    .cfg_div_we(cfg_div_we),
    .cfg_div   (cfg_div),
    .s_tick    (s_tick),
    .rx_data   (rx_data),
    .rx_done   (rx_done),
    .rd_en     (rd_en),
    .rd_data   (rd_data),
    .rd_valid  (rd_valid),
    .flush     (flush),
    .ovr_clr   (ovr_clr),
    .thresh    (thresh),
    .count     (count),
    .empty     (empty),
    .full      (full),
    .overrun   (overrun),
    .irq       (irq)
  );

  always #5 clk = ~clk;

  // Model: ticks land every max(div,1) enabled clocks since the last restart; FIFO is a queue.
  always @(posedge clk) begin
    bit pushReq;
    if (rst) begin
      mDiv = 326; mElapsed = 0; mTick = 0; mPrevDone = 0;
      mQ.delete(); mRdData = 8'h00; mRdValid = 0; mOverrun = 0; mIrq = 0;
    end else begin
      if (cfg_div_we) begin
        mDiv = int'(cfg_div); mElapsed = 0; mTick = 0;
      end else if (!en) begin
        mElapsed = 0; mTick = 0;
      end else begin
        mElapsed++;
        mTick = (mElapsed % ((mDiv < 2) ? 1 : mDiv)) == 0;
      end
      pushReq   = rx_done && !mPrevDone && en;
      mPrevDone = rx_done;
      if (ovr_clr) mOverrun = 0;
      mRdValid = 0;
      if (flush) begin
        mQ.delete();
      end else begin
        if (rd_en && mQ.size() > 0) begin
          mRdData  = mQ.pop_front();
          mRdValid = 1;
        end
        if (pushReq) begin
          if (mQ.size() < DEPTH) mQ.push_back(rx_data);
          else mOverrun = 1;
        end
      end
      mIrq = mOverrun || (thresh != 0 && mQ.size() >= int'(thresh));
    end
  end

  task automatic clk1();
    @(posedge clk);
    #1;
  endtask

  task automatic pushByte(input logic [7:0] b);
    rx_data = b; rx_done = 1'b1;
    clk1();
    rx_done = 1'b0;
    clk1();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    clk1();
    rst = 1'b0;
    nChecks++;
    if ({s_tick, rd_valid, overrun, irq, full} !== 5'b0) begin
      nFails++;
      $display("FAIL reset_flags: got %b expected 00000", {s_tick, rd_valid, overrun, irq, full});
    end
    nChecks++;
    if (empty !== 1'b1 || count !== 4'd0) begin
      nFails++;
      $display("FAIL reset_count: got empty=%b count=%0d expected empty=1 count=0", empty, count);
    end
    nChecks++;
    if (rd_data !== 8'h00) begin
      nFails++;
      $display("FAIL reset_rd_data: got %h expected 00", rd_data);
    end
  endtask

  task automatic test_baud();
    int nt, gap;
    en = 1'b1; cfg_div = 16'd4; cfg_div_we = 1'b1;
    clk1();
    cfg_div_we = 1'b0;
    nt = 0;
    for (int i = 0; i < 20; i++) begin
      clk1();
      if (s_tick === 1'b1) nt++;
      nChecks++;
      if (s_tick !== mTick) begin
        nFails++;
        $display("FAIL baud_div4 cyc%0d: got %b expected %b", i, s_tick, mTick);
      end
    end
    nChecks++;
    if (nt != 5) begin
      nFails++;
      $display("FAIL baud_div4_count: got %0d ticks expected 5", nt);
    end
    clk1();
    clk1();
    cfg_div = 16'd10; cfg_div_we = 1'b1;
    clk1();
    cfg_div_we = 1'b0;
    gap = 0;
    for (int i = 1; i <= 30 && gap == 0; i++) begin
      clk1();
      if (s_tick === 1'b1) gap = i;
    end
    nChecks++;
    if (gap != 10) begin
      nFails++;
      $display("FAIL baud_reload_gap: got %0d clks expected 10", gap);
    end
    cfg_div = 16'd0; cfg_div_we = 1'b1;
    clk1();
    cfg_div_we = 1'b0;
    for (int i = 0; i < 8; i++) begin
      clk1();
      nChecks++;
      if (s_tick !== 1'b1) begin
        nFails++;
        $display("FAIL baud_div0 cyc%0d: got %b expected 1", i, s_tick);
      end
    end
  endtask

  task automatic test_edge_capture();
    rx_data = 8'hA5; rx_done = 1'b1;
    for (int i = 0; i < 50; i++) clk1();
    rx_done = 1'b0;
    nChecks++;
    if (count !== 4'd1 || mQ.size() != 1) begin
      nFails++;
      $display("FAIL edge_one_push: got count=%0d expected 1", count);
    end
    rd_en = 1'b1;
    clk1();
    rd_en = 1'b0;
    nChecks++;
    if (rd_valid !== 1'b1 || rd_data !== 8'hA5 || empty !== 1'b1) begin
      nFails++;
      $display("FAIL edge_read: got valid=%b data=%h empty=%b expected 1 a5 1",
               rd_valid, rd_data, empty);
    end
    clk1();
    nChecks++;
    if (rd_valid !== 1'b0) begin
      nFails++;
      $display("FAIL edge_valid_pulse: got %b expected 0", rd_valid);
    end
  endtask

  task automatic test_fill_overflow();
    for (int i = 1; i <= 8; i++) pushByte(8'(i));
    nChecks++;
    if (full !== 1'b1 || count !== 4'd8) begin
      nFails++;
      $display("FAIL fill_full: got full=%b count=%0d expected 1 8", full, count);
    end
    pushByte(8'h09);
    nChecks++;
    if (overrun !== 1'b1 || irq !== 1'b1 || count !== 4'd8) begin
      nFails++;
      $display("FAIL fill_overrun: got ovr=%b irq=%b count=%0d expected 1 1 8",
               overrun, irq, count);
    end
    rd_en = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      clk1();
      nChecks++;
      if (rd_valid !== 1'b1 || rd_data !== 8'(i)) begin
        nFails++;
        $display("FAIL fill_pop%0d: got valid=%b data=%h expected 1 %h", i, rd_valid, rd_data,
                 8'(i));
      end
    end
    rd_en = 1'b0; ovr_clr = 1'b1;
    clk1();
    ovr_clr = 1'b0;
    nChecks++;
    if (overrun !== 1'b0 || irq !== 1'b0 || empty !== 1'b1) begin
      nFails++;
      $display("FAIL fill_ovr_clr: got ovr=%b irq=%b empty=%b expected 0 0 1", overrun, irq, empty);
    end
  endtask

  task automatic test_full_push_pop();
    for (int i = 0; i < 8; i++) pushByte(8'h10 + 8'(i));
    rx_data = 8'h55; rx_done = 1'b1; rd_en = 1'b1;
    clk1();
    rx_done = 1'b0; rd_en = 1'b0;
    nChecks++;
    if (overrun !== 1'b0 || count !== 4'd8 || rd_data !== 8'h10) begin
      nFails++;
      $display("FAIL full_pushpop: got ovr=%b count=%0d data=%h expected 0 8 10",
               overrun, count, rd_data);
    end
    rd_en = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      clk1();
      nChecks++;
      if (rd_data !== ((i == 8) ? 8'h55 : 8'h10 + 8'(i))) begin
        nFails++;
        $display("FAIL full_pushpop_order%0d: got %h expected %h", i, rd_data,
                 (i == 8) ? 8'h55 : 8'h10 + 8'(i));
      end
    end
    rd_en = 1'b0;
    clk1();
  endtask

  task automatic test_thresh_flush();
    thresh = 4'd3;
    for (int i = 0; i < 3; i++) begin
      rx_data = 8'hC0 + 8'(i); rx_done = 1'b1;
      clk1();
      rx_done = 1'b0;
      nChecks++;
      if (irq !== (i == 2)) begin
        nFails++;
        $display("FAIL thresh_irq push%0d: got %b expected %b", i, irq, i == 2);
      end
      clk1();
    end
    flush = 1'b1; rx_done = 1'b1; rd_en = 1'b1; rx_data = 8'hEE;
    clk1();
    flush = 1'b0; rx_done = 1'b0; rd_en = 1'b0;
    nChecks++;
    if (count !== 4'd0 || irq !== 1'b0 || empty !== 1'b1 || rd_valid !== 1'b0) begin
      nFails++;
      $display("FAIL flush: got count=%0d irq=%b empty=%b valid=%b expected 0 0 1 0",
               count, irq, empty, rd_valid);
    end
    thresh = 4'd0;
  endtask

  task automatic test_enable_reset();
    int gap;
    en = 1'b0;
    for (int i = 0; i < 8; i++) begin
      rx_done = i[0];
      rx_data = 8'(i);
      clk1();
      nChecks++;
      if (s_tick !== 1'b0 || count !== 4'd0) begin
        nFails++;
        $display("FAIL disabled cyc%0d: got tick=%b count=%0d expected 0 0", i, s_tick, count);
      end
    end
    rx_done = 1'b0; en = 1'b1;
    pushByte(8'h3C);
    pushByte(8'h4D);
    rx_done = 1'b1; rst = 1'b1;
    clk1();
    rst = 1'b0; rx_done = 1'b0;
    nChecks++;
    if ({s_tick, rd_valid, overrun, irq, full, empty, count, rd_data} !== {5'b0, 1'b1, 4'd0, 8'h00})
    begin
      nFails++;
      $display("FAIL midstream_reset: got %b expected %b",
               {s_tick, rd_valid, overrun, irq, full, empty, count, rd_data},
               {5'b0, 1'b1, 4'd0, 8'h00});
    end
    gap = 0;
    for (int i = 1; i <= 400 && gap == 0; i++) begin
      clk1();
      if (s_tick === 1'b1) gap = i;
    end
    nChecks++;
    if (gap != 326) begin
      nFails++;
      $display("FAIL reset_divisor: got first tick after %0d clks expected 326", gap);
    end
  endtask

  task automatic test_random();
    logic [17:0] expv, gotv;
    for (int i = 0; i < 3000; i++) begin
      rst        = ($urandom_range(0, 199) == 0);
      en         = ($urandom_range(0, 9) != 0);
      cfg_div_we = ($urandom_range(0, 49) == 0);
      cfg_div    = 16'($urandom_range(0, 6));
      rx_data    = 8'($urandom);
      rx_done    = $urandom_range(0, 1) == 1;
      rd_en      = ($urandom_range(0, 9) < 4);
      flush      = ($urandom_range(0, 39) == 0);
      ovr_clr    = ($urandom_range(0, 19) == 0);
      thresh     = 4'($urandom_range(0, 8));
      clk1();
      expv = {mTick, mRdValid, mRdData, 4'(mQ.size()), mQ.size() == 0, mQ.size() == DEPTH,
              mOverrun, mIrq};
      gotv = {s_tick, rd_valid, rd_data, count, empty, full, overrun, irq};
      nChecks++;
      if (gotv !== expv) begin
        nFails++;
        $display("FAIL random cyc%0d {tick,valid,data,count,empty,full,ovr,irq}: got %h expected %h",
                 i, gotv, expv);
      end
    end
    rst = 1'b0; cfg_div_we = 1'b0; rx_done = 1'b0; rd_en = 1'b0; flush = 1'b0; ovr_clr = 1'b0;
    clk1();
  endtask

  initial begin
    rst = 1'b1; en = 1'b0; cfg_div_we = 1'b0; cfg_div = '0; rx_data = '0; rx_done = 1'b0;
    rd_en = 1'b0; flush = 1'b0; ovr_clr = 1'b0; thresh = '0;
    #1;
    test_reset();
    test_baud();
    test_edge_capture();
    test_fill_overflow();
    test_full_push_pop();
    test_thresh_flush();
    test_enable_reset();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation still running at time limit");
    $fatal(1, "watchdog expired");
  end

endmodule
